// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Instruction fetch address generator. Supports increment,
//            absolute jump, signed relative branch and call/return through
//            an internal LIFO return stack. Sticky error flags record a call
//            into a full stack and a return from an empty stack.
// Ports    : clk         rising-edge clock
//            reset       asynchronous reset, active-low
//            enable      1 = advance this cycle, 0 = stall (hold)
//            jump        absolute jump to target
//            branch      relative branch by offset
//            call        push return address, jump to target
//            ret         pop return address into pc
//            target      jump/call destination
//            offset      two's-complement branch displacement
//            clr_err     synchronous clear of sticky error flags
//            pc          current fetch address (registered)
//            sp          return-stack occupancy, 0..DEPTH
//            stack_full  sp == DEPTH
//            stack_empty sp == 0
//            ovf_err     sticky: call attempted while full
//            unf_err     sticky: ret attempted while empty
// Revision : 1.0  initial release
// ============================================================================
module program_sequencer #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        jump,
  input  logic                        branch,
  input  logic                        call,
  input  logic                        ret,
  input  logic [WIDTH-1:0]            target,
  input  logic [WIDTH-1:0]            offset,
  input  logic                        clr_err,
  output logic [WIDTH-1:0]            pc,
  output logic [$clog2(DEPTH):0]      sp,
  output logic                        stack_full,
  output logic                        stack_empty,
  output logic                        ovf_err,
  output logic                        unf_err
);

  // Occupancy needs to represent 0..DEPTH inclusive, hence one extra bit.
  localparam int                c_SP_W     = $clog2(DEPTH) + 1;
  // Index into the stack array; at least one bit even for a single entry.
  localparam int                c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_SP_W-1:0] c_SP_DEPTH = c_SP_W'(DEPTH);
  localparam logic [c_SP_W-1:0] c_SP_ONE   = c_SP_W'(1);
  localparam logic [WIDTH-1:0]  c_PC_ONE   = WIDTH'(1);

  logic [WIDTH-1:0]   r_pc;
  logic [c_SP_W-1:0]  r_sp;
  logic               r_ovf_err;
  logic               r_unf_err;
  logic [WIDTH-1:0]   r_stack [DEPTH];

  logic [WIDTH-1:0]   w_pc_inc;
  logic [WIDTH-1:0]   w_pc_nxt;
  logic [c_SP_W-1:0]  w_sp_nxt;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_ovf_set;
  logic               w_unf_set;

  assign w_full   = (r_sp == c_SP_DEPTH);
  assign w_empty  = (r_sp == '0);
  // Wraps naturally: the return address pushed at the top address is 0.
  assign w_pc_inc = r_pc + c_PC_ONE;
  // Write slot is the current occupancy, read slot is the entry below it.
  // Both are only used when the respective full/empty guard allows it.
  assign w_wr_idx = c_IDX_W'(r_sp);
  assign w_rd_idx = c_IDX_W'(r_sp - c_SP_ONE);

  // Next-state selection. Strobe priority: ret > call > jump > branch > inc.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (enable) begin
      if (ret) begin
        if (!w_empty) begin
          w_pc_nxt = r_stack[w_rd_idx];
          w_sp_nxt = r_sp - c_SP_ONE;
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_unf_set = 1'b1;
        end
      end else if (call) begin
        if (!w_full) begin
          w_push   = 1'b1;
          w_pc_nxt = target;
          w_sp_nxt = r_sp + c_SP_ONE;
        end else begin
          // Refused call behaves as a plain increment.
          w_pc_nxt  = w_pc_inc;
          w_ovf_set = 1'b1;
        end
      end else if (jump) begin
        w_pc_nxt = target;
      end else if (branch) begin
        // Same-width addition is the sign-extended add modulo 2^WIDTH.
        w_pc_nxt = r_pc + offset;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_VEC;
      r_sp      <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_sp      <= w_sp_nxt;
      // A new error in the same cycle as a clear keeps the flag set.
      r_ovf_err <= w_ovf_set | (r_ovf_err & ~clr_err);
      r_unf_err <= w_unf_set | (r_unf_err & ~clr_err);
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  // A reset during a call is discarded because sp is cleared regardless.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_wr_idx] <= w_pc_inc;
    end
  end

  assign pc          = r_pc;
  assign sp          = r_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign ovf_err     = r_ovf_err;
  assign unf_err     = r_unf_err;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Self-checking bench for program_sequencer (WIDTH=8, DEPTH=4).
//            A behavioural model predicts each cycle's outputs into a
//            scoreboard queue; entries are popped and compared after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       jump;
  logic       branch;
  logic       call;
  logic       ret;
  logic [7:0] target;
  logic [7:0] offset;
  logic       clr_err;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       ovf_err;
  logic       unf_err;

  program_sequencer #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VEC (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .jump        (jump),
    .branch      (branch),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .offset      (offset),
    .clr_err     (clr_err),
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       r_sb [$];
  int         n_total = 0;
  int         n_bad   = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [2:0] m_sp;
  logic [7:0] m_stack [4];
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc  = 8'h00;
    m_sp  = 3'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state(input exp_t e);
    chk("pc",    {24'd0, pc},          {24'd0, e.pc});
    chk("sp",    {29'd0, sp},          {29'd0, e.sp});
    chk("full",  {31'd0, stack_full},  {31'd0, (e.sp == 3'd4)});
    chk("empty", {31'd0, stack_empty}, {31'd0, (e.sp == 3'd0)});
    chk("ovf",   {31'd0, ovf_err},     {31'd0, e.ovf});
    chk("unf",   {31'd0, unf_err},     {31'd0, e.unf});
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic cyc(input logic en, input logic r, input logic c, input logic j,
                     input logic b, input logic [7:0] tgt, input logic [7:0] off,
                     input logic clr);
    exp_t       e;
    logic [7:0] npc;
    logic       o;
    logic       u;
    @(negedge clk);
    enable = en; ret = r; call = c; jump = j; branch = b;
    target = tgt; offset = off; clr_err = clr;
    npc = m_pc; o = 1'b0; u = 1'b0;
    if (en) begin
      if (r) begin
        if (m_sp != 3'd0) begin
          m_sp = m_sp - 3'd1;
          npc  = m_stack[m_sp[1:0]];
        end else begin
          npc = m_pc + 8'd1;
          u   = 1'b1;
        end
      end else if (c) begin
        if (m_sp < 3'd4) begin
          m_stack[m_sp[1:0]] = m_pc + 8'd1;
          m_sp = m_sp + 3'd1;
          npc  = tgt;
        end else begin
          npc = m_pc + 8'd1;
          o   = 1'b1;
        end
      end else if (j) begin
        npc = tgt;
      end else if (b) begin
        npc = m_pc + off;
      end else begin
        npc = m_pc + 8'd1;
      end
    end
    m_pc  = npc;
    m_ovf = o | (m_ovf & ~clr);
    m_unf = u | (m_unf & ~clr);
    e.pc = m_pc; e.sp = m_sp; e.ovf = m_ovf; e.unf = m_unf;
    r_sb.push_back(e);
    @(posedge clk);
    #1;
    if (r_sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      check_state(r_sb.pop_front());
    end
  endtask

  task automatic idle(input logic en);
    cyc(en, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_jump(input logic [7:0] t);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t, 8'h00, 1'b0);
  endtask

  task automatic do_call(input logic [7:0] t);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t, 8'h00, 1'b0);
  endtask

  task automatic do_ret();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_branch(input logic [7:0] off);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, off, 1'b0);
  endtask

  task automatic quiet_inputs();
    enable = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    target = 8'h00; offset = 8'h00; clr_err = 1'b0;
  endtask

  initial begin
    exp_t e0;
    quiet_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    e0.pc = 8'h00; e0.sp = 3'd0; e0.ovf = 1'b0; e0.unf = 1'b0;
    check_state(e0);
    @(negedge clk);
    reset = 1'b1;

    // 1: free-running count with wrap
    for (int i = 0; i < 300; i++) begin
      idle(1'b1);
      if (i == 255) chk("wrap0", {24'd0, pc}, 32'd0);
    end
    // Asynchronous reset mid-count, checked before any rising edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    quiet_inputs();
    #1;
    chk("async_pc", {24'd0, pc}, 32'd0);
    chk("async_sp", {29'd0, sp}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // 2: relative branch, negative and wrapping
    do_jump(8'h10);
    do_branch(8'hFC);
    chk("br_neg", {24'd0, pc}, 32'h0C);
    do_jump(8'hFE);
    do_branch(8'h05);
    chk("br_wrap", {24'd0, pc}, 32'h03);

    // 3: single call/return
    do_jump(8'h20);
    do_call(8'h80);
    chk("call_pc", {24'd0, pc}, 32'h80);
    do_ret();
    chk("ret_pc", {24'd0, pc}, 32'h21);

    // 4: nested calls, overflow, LIFO returns, underflow, clear
    do_jump(8'h40);
    do_call(8'h50);
    do_call(8'h60);
    do_call(8'h70);
    do_call(8'h90);
    chk("full4", {31'd0, stack_full}, 32'd1);
    do_call(8'hA0);
    chk("ovf_pc", {24'd0, pc}, 32'h91);
    chk("ovf_flag", {31'd0, ovf_err}, 32'd1);
    do_ret();
    chk("lifo1", {24'd0, pc}, 32'h71);
    do_ret();
    do_ret();
    do_ret();
    chk("lifo4", {24'd0, pc}, 32'h41);
    do_ret();
    chk("unf_pc", {24'd0, pc}, 32'h42);
    chk("unf_flag", {31'd0, unf_err}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("clr_ovf", {31'd0, ovf_err}, 32'd0);
    chk("clr_unf", {31'd0, unf_err}, 32'd0);
    // Set wins over a simultaneous clear
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("set_wins", {31'd0, unf_err}, 32'd1);
    // Clear acts while stalled
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("stall_clr", {31'd0, unf_err}, 32'd0);

    // Return address wraps when calling from the top address
    do_jump(8'hFF);
    do_call(8'h10);
    do_ret();
    chk("ret_wrap", {24'd0, pc}, 32'h00);

    // 5: priority and stall
    do_jump(8'h30);
    do_call(8'h35);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 8'h04, 1'b0);
    chk("prio_pc", {24'd0, pc}, 32'h31);
    chk("prio_sp", {29'd0, sp}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0);
      chk("stall_pc", {24'd0, pc}, 32'h31);
    end
    // call beats jump/branch
    do_call(8'h55);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 8'h10, 1'b0);
    chk("call_prio", {24'd0, pc}, 32'h66);
    // jump beats branch
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'h10, 1'b0);
    chk("jump_prio", {24'd0, pc}, 32'h77);

    // Random mix of strobes against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
